nibble_word_gather: RTL and testbench

Sequencer upstream of the 8:1 nibble multiplexer (4-bit, active-low enable). Drives the mux select lines and enable, samples the returned nibble each cycle, and assembles up to eight nibbles into a 32-bit word. Presents the word on a valid/ready handshake to downstream logic.

---
 rtl/nscan_pkg.sv | 20 ++
 rtl/nscan_sel_cnt.sv | 45 ++++
 rtl/nibble_word_gather.sv | 141 ++++++++++++++
 tb/tb_nibble_word_gather.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/nscan_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nscan_pkg
// Purpose  : Shared widths and FSM state encoding for nibble_word_gather.
// Revision : 1.0
// ============================================================================
package nscan_pkg;

   localparam int NIB_W  = 4;
   localparam int SEL_W  = 3;
   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/nscan_sel_cnt.sv
`default_nettype none
// ============================================================================
// Module   : nscan_sel_cnt
// Purpose  : Loadable 3-bit up/down mux select counter with last-index flag.
// Revision : 1.0
// ============================================================================
module nscan_sel_cnt
   import nscan_pkg::*;
#(
   parameter int NIBBLES   = 8,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   output logic [SEL_W-1:0] sel,
   output logic             last
);

   localparam logic [SEL_W-1:0] c_first = SEL_W'(MSB_FIRST ? NIBBLES - 1 : 0);
   localparam logic [SEL_W-1:0] c_last  = SEL_W'(MSB_FIRST ? 0 : NIBBLES - 1);

   logic [SEL_W-1:0] r_sel;

   // Load wins over step so the post-last value is never observed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sel <= '0;
      end else if (load) begin
         r_sel <= c_first;
      end else if (step) begin
         if (MSB_FIRST) begin
            r_sel <= r_sel - SEL_W'(1);
         end else begin
            r_sel <= r_sel + SEL_W'(1);
         end
      end
   end

   assign sel  = r_sel;
   assign last = (r_sel == c_last);

endmodule
`default_nettype wire

// File: rtl/nibble_word_gather.sv
`default_nettype none
// ============================================================================
// Module   : nibble_word_gather
// Purpose  : Sequences an 8:1 nibble mux and gathers nibbles into a 32-bit
//            word offered on a valid/ready handshake. Optional parity output
//            enabled by defining NSCAN_PARITY_EN.
// Revision : 1.0
// ============================================================================
module nibble_word_gather
   import nscan_pkg::*;
#(
   parameter int NIBBLES   = 8,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   output logic [SEL_W-1:0]  sel,
   output logic              en_n,
   input  logic [NIB_W-1:0]  nib_in,
   output logic              busy,
   output logic [WORD_W-1:0] word_out,
   output logic              word_valid,
`ifdef NSCAN_PARITY_EN
   output logic              parity,
`endif
   input  logic              word_ready
);

   state_t            r_state;
   logic              r_en_n;
   logic              r_busy;
   logic              r_word_valid;
   logic [WORD_W-1:0] r_word;
   logic [WORD_W-1:0] w_word_next;
   logic              w_last;
   logic              w_accept;
   logic              w_load;
   logic              w_step;
   logic              w_scan;

   assign w_scan   = (r_state == SCAN);
   assign w_accept = ~abort & start &
                     ((r_state == IDLE) | ((r_state == DONE) & word_ready));
   assign w_load   = abort | w_accept | (w_scan & w_last);
   assign w_step   = ~abort & w_scan & ~w_last;

   nscan_sel_cnt #(
      .NIBBLES   (NIBBLES),
      .MSB_FIRST (MSB_FIRST)
   ) u_sel_cnt (
      .clk  (clk),
      .rst  (rst),
      .load (w_load),
      .step (w_step),
      .sel  (sel),
      .last (w_last)
   );

   // Placement is by select index, so bits above 4*NIBBLES-1 are never written.
   always_comb begin
      w_word_next = r_word;
      w_word_next[{sel, 2'b00} +: NIB_W] = nib_in;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_en_n       <= 1'b1;
         r_busy       <= 1'b0;
         r_word_valid <= 1'b0;
         r_word       <= '0;
      end else if (abort) begin
         r_state      <= IDLE;
         r_en_n       <= 1'b1;
         r_busy       <= 1'b0;
         r_word_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_word  <= '0;
                  r_en_n  <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= SCAN;
               end
            end
            SCAN: begin
               r_word <= w_word_next;
               if (w_last) begin
                  r_en_n       <= 1'b1;
                  r_busy       <= 1'b0;
                  r_word_valid <= 1'b1;
                  r_state      <= DONE;
               end
            end
            DONE: begin
               if (word_ready) begin
                  r_word_valid <= 1'b0;
                  if (start) begin
                     r_word  <= '0;
                     r_en_n  <= 1'b0;
                     r_busy  <= 1'b1;
                     r_state <= SCAN;
                  end else begin
                     r_state <= IDLE;
                  end
               end
            end
            default: begin
               r_en_n       <= 1'b1;
               r_busy       <= 1'b0;
               r_word_valid <= 1'b0;
               r_state      <= IDLE;
            end
         endcase
      end
   end

`ifdef NSCAN_PARITY_EN
   logic r_parity;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_parity <= 1'b0;
      end else if (~abort & w_scan & w_last) begin
         r_parity <= ^w_word_next;
      end
   end

   assign parity = r_parity;
`endif

   assign en_n       = r_en_n;
   assign busy       = r_busy;
   assign word_out   = r_word;
   assign word_valid = r_word_valid;

endmodule
`default_nettype wire

// File: tb/tb_nibble_word_gather.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_word_gather
// Purpose  : Directed self-checking bench; instances 0/1/2 are
//            (NIBBLES,MSB_FIRST) = (8,0), (8,1), (3,0).
// Revision : 1.0
// ============================================================================
module tb_nibble_word_gather;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_v [3];
   logic        abort_v [3];
   logic        ready_v [3];
   logic [31:0] pat_v   [3];
   logic [2:0]  sel_v   [3];
   logic        en_n_v  [3];
   logic        busy_v  [3];
   logic [31:0] word_v  [3];
   logic        valid_v [3];
`ifdef NSCAN_PARITY_EN
   logic        par_v   [3];
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      logic [3:0] nib;
      assign nib = pat_v[g][{sel_v[g], 2'b00} +: 4];

      nibble_word_gather #(
         .NIBBLES   (g == 2 ? 3 : 8),
         .MSB_FIRST (g == 1)
      ) u_dut (
         .clk        (clk),
         .rst        (rst),
         .start      (start_v[g]),
         .abort      (abort_v[g]),
         .sel        (sel_v[g]),
         .en_n       (en_n_v[g]),
         .nib_in     (nib),
         .busy       (busy_v[g]),
         .word_out   (word_v[g]),
         .word_valid (valid_v[g]),
`ifdef NSCAN_PARITY_EN
         .parity     (par_v[g]),
`endif
         .word_ready (ready_v[g])
      );
   end

   typedef struct {
      logic [31:0] pat;
      logic [31:0] exp;
      logic        par;
   } vec_t;

   vec_t tbl [5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic kick(input int d);
      start_v[d] = 1'b1;
      @(negedge clk);
      start_v[d] = 1'b0;
      check("kick_en_n", 32'(en_n_v[d]), 32'd0);
      check("kick_busy", 32'(busy_v[d]), 32'd1);
   endtask

   // Follows one gather from the accept edge until word_valid (bounded).
   task automatic collect(input int d, input int n, input bit msb,
                          input logic [31:0] exp, input logic par, input bit poke);
      int lat = 0;
      int low = 0;
      while (!valid_v[d] && lat < 40) begin
         check("sel_seq", 32'(sel_v[d]), msb ? 32'(n - 1 - lat) : 32'(lat));
         if (!en_n_v[d]) low++;
         start_v[d] = poke && (lat == 1);
         @(negedge clk);
         lat++;
      end
      start_v[d] = 1'b0;
      check("latency", 32'(lat), 32'(n));
      check("en_n_low_cycles", 32'(low), 32'(n));
      check("done_en_n", 32'(en_n_v[d]), 32'd1);
      check("done_sel_first", 32'(sel_v[d]), msb ? 32'(n - 1) : 32'd0);
      check("word_out", word_v[d], exp);
`ifdef NSCAN_PARITY_EN
      check("parity", 32'(par_v[d]), 32'(par));
`else
      if (par === 1'bx) check("parity_ref", 32'(par), 32'd0);
`endif
   endtask

   task automatic ack(input int d);
      ready_v[d] = 1'b1;
      @(negedge clk);
      ready_v[d] = 1'b0;
      check("ack_valid", 32'(valid_v[d]), 32'd0);
      check("ack_busy", 32'(busy_v[d]), 32'd0);
      check("ack_en_n", 32'(en_n_v[d]), 32'd1);
   endtask

   initial begin
      logic [31:0] held;
      for (int i = 0; i < 3; i++) begin
         start_v[i] = 1'b0;
         abort_v[i] = 1'b0;
         ready_v[i] = 1'b0;
         pat_v[i]   = 32'h87654321;
      end
      tbl[0] = '{pat: 32'h87654321, exp: 32'h87654321, par: 1'b1};
      tbl[1] = '{pat: 32'hDEADBEEF, exp: 32'hDEADBEEF, par: 1'b0};
      tbl[2] = '{pat: 32'h00000000, exp: 32'h00000000, par: 1'b0};
      tbl[3] = '{pat: 32'hFFFFFFFF, exp: 32'hFFFFFFFF, par: 1'b0};
      tbl[4] = '{pat: 32'h00000007, exp: 32'h00000007, par: 1'b1};

      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check("rst_sel", 32'(sel_v[i]), 32'd0);
         check("rst_en_n", 32'(en_n_v[i]), 32'd1);
         check("rst_busy", 32'(busy_v[i]), 32'd0);
         check("rst_word", word_v[i], 32'd0);
         check("rst_valid", 32'(valid_v[i]), 32'd0);
`ifdef NSCAN_PARITY_EN
         check("rst_parity", 32'(par_v[i]), 32'd0);
`endif
      end
      rst = 1'b0;
      @(negedge clk);

      // Asynchronous reset with three nibbles already sampled
      kick(0);
      repeat (3) @(negedge clk);
      check("pre_rst_word", word_v[0], 32'h00000321);
      #2 rst = 1'b1;
      #1;
      check("async_rst_sel", 32'(sel_v[0]), 32'd0);
      check("async_rst_en_n", 32'(en_n_v[0]), 32'd1);
      check("async_rst_valid", 32'(valid_v[0]), 32'd0);
      check("async_rst_word", word_v[0], 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         pat_v[0] = tbl[i].pat;
         kick(0);
         collect(0, 8, 1'b0, tbl[i].exp, tbl[i].par, 1'b0);
         ack(0);
      end

      // MSB-first: select walks 7..0, placement still by index
      pat_v[1] = 32'h87654321;
      kick(1);
      collect(1, 8, 1'b1, 32'h87654321, 1'b1, 1'b0);
      ack(1);
      check("msb_idle_sel", 32'(sel_v[1]), 32'd7);

      // Three nibbles, upper pattern bits must not leak; start in SCAN ignored
      pat_v[2] = 32'hFFFFFCBA;
      kick(2);
      collect(2, 3, 1'b0, 32'h00000CBA, 1'b1, 1'b1);
      ack(2);
      @(negedge clk);
      @(negedge clk);
      check("n3_no_restart", 32'(busy_v[2]), 32'd0);
      check("n3_no_valid", 32'(valid_v[2]), 32'd0);

      // Backpressure, then back-to-back restart from DONE
      pat_v[0] = 32'hDEADBEEF;
      kick(0);
      collect(0, 8, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
      held = word_v[0];
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", 32'(valid_v[0]), 32'd1);
         check("bp_word", word_v[0], 32'hDEADBEEF);
         if (i < 4) @(negedge clk);
      end
      check("bp_held", word_v[0], held);
      pat_v[0]   = 32'h87654321;
      ready_v[0] = 1'b1;
      start_v[0] = 1'b1;
      @(negedge clk);
      ready_v[0] = 1'b0;
      start_v[0] = 1'b0;
      check("b2b_valid", 32'(valid_v[0]), 32'd0);
      check("b2b_busy", 32'(busy_v[0]), 32'd1);
      check("b2b_en_n", 32'(en_n_v[0]), 32'd0);
      check("b2b_word_cleared", word_v[0], 32'd0);
      collect(0, 8, 1'b0, 32'h87654321, 1'b1, 1'b0);
      ack(0);

      // Abort after four nibbles: partial word held, no delivery
      kick(0);
      repeat (4) @(negedge clk);
      abort_v[0] = 1'b1;
      start_v[0] = 1'b1;
      @(negedge clk);
      abort_v[0] = 1'b0;
      start_v[0] = 1'b0;
      check("abort_valid", 32'(valid_v[0]), 32'd0);
      check("abort_en_n", 32'(en_n_v[0]), 32'd1);
      check("abort_busy", 32'(busy_v[0]), 32'd0);
      check("abort_word", word_v[0], 32'h00004321);
      @(negedge clk);
      check("abort_idle", 32'(busy_v[0]), 32'd0);
      pat_v[0] = 32'h00000007;
      kick(0);
      check("fresh_cleared", word_v[0], 32'd0);
      collect(0, 8, 1'b0, 32'h00000007, 1'b1, 1'b0);
      ack(0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
